// File: rtl/composite_pkg.sv
// Shared constants, sine table and rounding helper for the composite/chroma decoder.
package composite_pkg;

    localparam int SIN_W     = 12;
    localparam int LUT_IDX_W = 8;
    localparam int SIN_PEAK  = 2047;
    localparam int QTR_W     = LUT_IDX_W - 2;

    typedef logic signed [SIN_W-1:0] sin_t;

    // Quarter-wave table: round(SIN_PEAK * sin(pi/2 * k/64)), k = 0..64.
    function automatic sin_t quarter_sin(input logic [QTR_W:0] k);
        sin_t v;
        case (k)
            7'd0:    v = 12'sd0;
            7'd1:    v = 12'sd50;
            7'd2:    v = 12'sd100;
            7'd3:    v = 12'sd151;
            7'd4:    v = 12'sd201;
            7'd5:    v = 12'sd251;
            7'd6:    v = 12'sd300;
            7'd7:    v = 12'sd350;
            7'd8:    v = 12'sd399;
            7'd9:    v = 12'sd449;
            7'd10:   v = 12'sd497;
            7'd11:   v = 12'sd546;
            7'd12:   v = 12'sd594;
            7'd13:   v = 12'sd642;
            7'd14:   v = 12'sd690;
            7'd15:   v = 12'sd737;
            7'd16:   v = 12'sd783;
            7'd17:   v = 12'sd830;
            7'd18:   v = 12'sd875;
            7'd19:   v = 12'sd920;
            7'd20:   v = 12'sd965;
            7'd21:   v = 12'sd1009;
            7'd22:   v = 12'sd1052;
            7'd23:   v = 12'sd1095;
            7'd24:   v = 12'sd1137;
            7'd25:   v = 12'sd1179;
            7'd26:   v = 12'sd1219;
            7'd27:   v = 12'sd1259;
            7'd28:   v = 12'sd1299;
            7'd29:   v = 12'sd1337;
            7'd30:   v = 12'sd1375;
            7'd31:   v = 12'sd1411;
            7'd32:   v = 12'sd1447;
            7'd33:   v = 12'sd1483;
            7'd34:   v = 12'sd1517;
            7'd35:   v = 12'sd1550;
            7'd36:   v = 12'sd1582;
            7'd37:   v = 12'sd1614;
            7'd38:   v = 12'sd1644;
            7'd39:   v = 12'sd1674;
            7'd40:   v = 12'sd1702;
            7'd41:   v = 12'sd1729;
            7'd42:   v = 12'sd1756;
            7'd43:   v = 12'sd1781;
            7'd44:   v = 12'sd1805;
            7'd45:   v = 12'sd1828;
            7'd46:   v = 12'sd1850;
            7'd47:   v = 12'sd1871;
            7'd48:   v = 12'sd1891;
            7'd49:   v = 12'sd1910;
            7'd50:   v = 12'sd1927;
            7'd51:   v = 12'sd1944;
            7'd52:   v = 12'sd1959;
            7'd53:   v = 12'sd1973;
            7'd54:   v = 12'sd1986;
            7'd55:   v = 12'sd1997;
            7'd56:   v = 12'sd2008;
            7'd57:   v = 12'sd2017;
            7'd58:   v = 12'sd2025;
            7'd59:   v = 12'sd2032;
            7'd60:   v = 12'sd2037;
            7'd61:   v = 12'sd2041;
            7'd62:   v = 12'sd2045;
            7'd63:   v = 12'sd2046;
            7'd64:   v = 12'sd2047;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Round-half-up arithmetic right shift, shared with the IIR low-pass stages.
    function automatic logic signed [31:0] reduce_round(input logic signed [31:0] value,
                                                        input int unsigned        shift);
        logic signed [31:0] half;
        half = (shift == 0) ? '0 : (32'sd1 <<< (shift - 1));
        return (value + half) >>> shift;
    endfunction

endpackage

// File: rtl/sine_quadrant_lut.sv
// Full-wave sine from the quarter-wave table by quadrant folding.
module sine_quadrant_lut
    import composite_pkg::*;
(
    input  logic [LUT_IDX_W-1:0]    idx,
    output logic signed [SIN_W-1:0] val
);

    localparam logic [QTR_W:0] QTR_LEN = {1'b1, {QTR_W{1'b0}}};

    logic [QTR_W:0] k_fwd;
    logic [QTR_W:0] k_rev;

    // Fold the index into the first quadrant and apply the quadrant sign.
    always_comb begin
        k_fwd = {1'b0, idx[QTR_W-1:0]};
        k_rev = QTR_LEN - k_fwd;
        case (idx[LUT_IDX_W-1 -: 2])
            2'b00:   val = quarter_sin(k_fwd);
            2'b01:   val = quarter_sin(k_rev);
            2'b10:   val = -quarter_sin(k_fwd);
            default: val = -quarter_sin(k_rev);
        endcase
    end

endmodule

// File: rtl/chroma_quadrature_mixer.sv
// Chroma quadrature mixer: line-reloaded NCO, sin/cos lookup and I/Q products, latency 3.
module chroma_quadrature_mixer #(
    parameter int PHASE_W   = 32,
    parameter int LUT_IDX_W = 8,
    parameter int SIN_W     = 12,
    parameter int IN_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [31:0]  in,
    input  logic [PHASE_W-1:0]  phase_inc,
    input  logic [PHASE_W-1:0]  phase_offset,
    input  logic                line_start,
    output logic                out_valid,
    output logic signed [31:0]  out_i,
    output logic signed [31:0]  out_q,
    output logic [PHASE_W-1:0]  phase
);

    import composite_pkg::*;

    localparam int PROD_W = IN_W + SIN_W;
    localparam logic [LUT_IDX_W-1:0] COS_OFS = {2'b01, {(LUT_IDX_W-2){1'b0}}};

    // NCO accumulator
    logic [PHASE_W-1:0]        acc_q, acc_d;

    // Stage 1: sample, phase index, valid
    logic                      s1_valid_q, s1_valid_d;
    logic signed [IN_W-1:0]    s1_x_q, s1_x_d;
    logic [LUT_IDX_W-1:0]      s1_idx_q, s1_idx_d;

    // Stage 2: sample, sin, cos, valid
    logic                      s2_valid_q, s2_valid_d;
    logic signed [IN_W-1:0]    s2_x_q, s2_x_d;
    logic signed [SIN_W-1:0]   s2_sin_q, s2_sin_d;
    logic signed [SIN_W-1:0]   s2_cos_q, s2_cos_d;

    // Stage 3: output registers
    logic                      out_valid_q, out_valid_d;
    logic signed [31:0]        out_i_q, out_i_d;
    logic signed [31:0]        out_q_q, out_q_d;

    logic [LUT_IDX_W-1:0]      cos_idx;
    logic signed [SIN_W-1:0]   lut_sin;
    logic signed [SIN_W-1:0]   lut_cos;
    logic signed [PROD_W-1:0]  prod_i;
    logic signed [PROD_W-1:0]  prod_q;
    logic                      in_hi_unused;

    // Only the low IN_W bits of the sample carry information.
    assign in_hi_unused = ^in[31:IN_W];

    assign cos_idx = s1_idx_q + COS_OFS;

    sine_quadrant_lut u_sin_lut (
        .idx (s1_idx_q),
        .val (lut_sin)
    );

    sine_quadrant_lut u_cos_lut (
        .idx (cos_idx),
        .val (lut_cos)
    );

    // NCO: line_start reloads the offset; a valid sample advances from whichever phase it used.
    always_comb begin
        acc_d = acc_q;
        if (line_start && in_valid) begin
            acc_d = phase_offset + phase_inc;
        end else if (line_start) begin
            acc_d = phase_offset;
        end else if (in_valid) begin
            acc_d = acc_q + phase_inc;
        end
    end

    // Stage 1: capture the sample and the phase index it is mixed with.
    always_comb begin
        s1_valid_d = in_valid;
        s1_x_d     = s1_x_q;
        s1_idx_d   = s1_idx_q;
        if (in_valid) begin
            s1_x_d   = in[IN_W-1:0];
            s1_idx_d = line_start ? phase_offset[PHASE_W-1 -: LUT_IDX_W]
                                  : acc_q[PHASE_W-1 -: LUT_IDX_W];
        end
    end

    // Stage 2: register the folded sin/cos values alongside the sample.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_x_d     = s2_x_q;
        s2_sin_d   = s2_sin_q;
        s2_cos_d   = s2_cos_q;
        if (s1_valid_q) begin
            s2_x_d   = s1_x_q;
            s2_sin_d = lut_sin;
            s2_cos_d = lut_cos;
        end
    end

    // Stage 3: full-width products, rounded back to sample scale; outputs hold between valids.
    always_comb begin
        prod_i      = PROD_W'(s2_x_q) * PROD_W'(s2_sin_q);
        prod_q      = PROD_W'(s2_x_q) * PROD_W'(s2_cos_q);
        out_valid_d = s2_valid_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        if (s2_valid_q) begin
            out_i_d = reduce_round(32'(prod_i), SIN_W - 1);
            out_q_d = reduce_round(32'(prod_q), SIN_W - 1);
        end
    end

    // State registers; reset flushes the pipeline and restarts the NCO at phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_idx_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_sin_q    <= '0;
            s2_cos_q    <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
        end else begin
            acc_q       <= acc_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_idx_q    <= s1_idx_d;
            s2_valid_q  <= s2_valid_d;
            s2_x_q      <= s2_x_d;
            s2_sin_q    <= s2_sin_d;
            s2_cos_q    <= s2_cos_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign phase     = acc_q;

endmodule

// File: tb/tb_chroma_quadrature_mixer.sv
// Directed bench for chroma_quadrature_mixer with hand-computed I/Q expectations.
module tb_chroma_quadrature_mixer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [31:0] in_s;
    logic [31:0]        phase_inc;
    logic [31:0]        phase_offset;
    logic               line_start;
    logic               out_valid;
    logic signed [31:0] out_i;
    logic signed [31:0] out_q;
    logic [31:0]        phase;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    chroma_quadrature_mixer #(
        .PHASE_W   (32),
        .LUT_IDX_W (8),
        .SIN_W     (12),
        .IN_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in           (in_s),
        .phase_inc    (phase_inc),
        .phase_offset (phase_offset),
        .line_start   (line_start),
        .out_valid    (out_valid),
        .out_i        (out_i),
        .out_q        (out_q),
        .phase        (phase)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
    task automatic send(input logic v, input int x, input logic ls);
        in_valid   = v;
        in_s       = x;
        line_start = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ev, input int ei, input int eq);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({tag, ".i"}, out_i, ei);
        check({tag, ".q"}, out_q, eq);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_s         = 0;
        line_start   = 1'b0;
        phase_inc    = '0;
        phase_offset = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 0, 0);
        check("reset.phase", phase, 32'h0000_0000);
        rst_n = 1'b1;

        // DC phase: output equals input on Q, zero on I
        phase_inc    = 32'h0000_0000;
        phase_offset = 32'h0000_0000;
        send(1'b1, 1000, 1'b1);
        send(1'b1, 1000, 1'b0);
        send(1'b1, 1000, 1'b0);
        expect_out("dc0", 1'b1, 0, 1000);
        send(1'b1, 1000, 1'b0);
        expect_out("dc1", 1'b1, 0, 1000);
        check("dc.phase", phase, 32'h0000_0000);
        send(1'b0, 0, 1'b0);
        send(1'b0, 0, 1'b0);
        send(1'b0, 0, 1'b0);
        expect_out("dc_idle", 1'b0, 0, 1000);

        // Quarter-turn NCO
        phase_inc    = 32'h4000_0000;
        phase_offset = 32'h0000_0000;
        send(1'b1, 1000, 1'b1);
        send(1'b1, 1000, 1'b0);
        send(1'b1, 1000, 1'b0);
        expect_out("qt0", 1'b1, 0, 1000);
        send(1'b1, 1000, 1'b0);
        expect_out("qt1", 1'b1, 1000, 0);
        check("qt.phase_wrap", phase, 32'h0000_0000);
        send(1'b1, 1000, 1'b0);
        expect_out("qt2", 1'b1, 0, -1000);
        send(1'b0, 4321, 1'b0);
        expect_out("qt3", 1'b1, -1000, 0);
        send(1'b0, 4321, 1'b0);
        expect_out("qt4", 1'b1, 0, 1000);
        send(1'b0, 4321, 1'b0);
        expect_out("qt_hold", 1'b0, 0, 1000);

        // Wrap and offset
        phase_inc    = 32'h4000_0000;
        phase_offset = 32'hC000_0000;
        send(1'b1, 1000, 1'b1);
        check("wrap.phase0", phase, 32'h0000_0000);
        send(1'b1, 1000, 1'b0);
        send(1'b1, 1000, 1'b0);
        expect_out("wrap0", 1'b1, -1000, 0);
        check("wrap.phase3", phase, 32'h8000_0000);
        send(1'b0, 4321, 1'b0);
        expect_out("wrap1", 1'b1, 0, 1000);
        send(1'b0, 4321, 1'b0);
        expect_out("wrap2", 1'b1, 1000, 0);
        send(1'b0, 4321, 1'b0);
        expect_out("wrap_hold", 1'b0, 1000, 0);

        // Gaps in in_valid: pattern 1,0,0,1,1,0,1
        phase_inc    = 32'h4000_0000;
        phase_offset = 32'h0000_0000;
        send(1'b1, 1000, 1'b1);
        send(1'b0, 4321, 1'b0);
        send(1'b0, 4321, 1'b0);
        expect_out("gap0", 1'b1, 0, 1000);
        send(1'b1, 1000, 1'b0);
        expect_out("gap1", 1'b0, 0, 1000);
        send(1'b1, 1000, 1'b0);
        expect_out("gap2", 1'b0, 0, 1000);
        send(1'b0, 4321, 1'b0);
        expect_out("gap3", 1'b1, 1000, 0);
        send(1'b1, 1000, 1'b0);
        expect_out("gap4", 1'b1, 0, -1000);
        send(1'b0, 4321, 1'b0);
        expect_out("gap5", 1'b0, 0, -1000);
        send(1'b0, 4321, 1'b0);
        expect_out("gap6", 1'b1, -1000, 0);
        send(1'b0, 4321, 1'b0);
        expect_out("gap7", 1'b0, -1000, 0);

        // Extremes and rounding
        phase_inc    = 32'h0000_0000;
        phase_offset = 32'h4000_0000;
        send(1'b1, -32768, 1'b1);
        phase_offset = 32'h0000_0000;
        send(1'b1, 1, 1'b1);
        send(1'b1, -1, 1'b0);
        expect_out("ext_neg_full", 1'b1, -32752, 0);
        send(1'b0, 4321, 1'b0);
        expect_out("ext_plus1", 1'b1, 0, 1);
        send(1'b0, 4321, 1'b0);
        expect_out("ext_minus1", 1'b1, 0, -1);
        send(1'b0, 4321, 1'b0);
        expect_out("ext_hold", 1'b0, 0, -1);

        // line_start without in_valid, then a valid sample uses the reloaded phase
        phase_inc    = 32'h4000_0000;
        phase_offset = 32'hC000_0000;
        send(1'b0, 999, 1'b1);
        check("ls_only.phase", phase, 32'hC000_0000);
        send(1'b1, 1000, 1'b0);
        check("ls_then_valid.phase", phase, 32'h0000_0000);
        send(1'b0, 4321, 1'b0);
        expect_out("ls_gap", 1'b0, 0, -1);
        send(1'b0, 4321, 1'b0);
        expect_out("ls_sample", 1'b1, -1000, 0);

        // Reset mid-stream flushes the pipeline and restarts the NCO at 0
        phase_inc    = 32'h4000_0000;
        phase_offset = 32'h4000_0000;
        send(1'b1, 1000, 1'b1);
        send(1'b1, 1000, 1'b0);
        send(1'b1, 1000, 1'b0);
        expect_out("pre_rst", 1'b1, 1000, 0);
        in_valid   = 1'b0;
        line_start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("mid_rst", 1'b0, 0, 0);
        check("mid_rst.phase", phase, 32'h0000_0000);
        #1;
        rst_n = 1'b1;
        send(1'b0, 4321, 1'b0);
        expect_out("flush0", 1'b0, 0, 0);
        send(1'b0, 4321, 1'b0);
        expect_out("flush1", 1'b0, 0, 0);
        send(1'b1, 1000, 1'b0);
        check("post_rst.phase", phase, 32'h4000_0000);
        send(1'b0, 4321, 1'b0);
        expect_out("post_rst_gap", 1'b0, 0, 0);
        send(1'b0, 4321, 1'b0);
        expect_out("post_rst_sample", 1'b1, 0, 1000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
